// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if: bundled Wishbone signals for the N-master round-robin arbiter
// Master slices are flattened, and master i occupies slice i of every m_* vector.
// modport slave  : the arbiter's view. It takes master requests and the slave response,
//                  and drives the muxed slave bus, the terminations, grant_o and timeout_o.
// modport master : the environment's view, with every direction reversed.
interface wb_rr_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int AW        = 30,
  parameter int DW        = 32
);
  localparam int GW = $clog2(N_MASTERS);
  logic [N_MASTERS*AW-1:0]     m_adr_i;
  logic [N_MASTERS*DW-1:0]     m_dat_i;
  logic [N_MASTERS*DW/8-1:0]   m_sel_i;
  logic [N_MASTERS-1:0]        m_cyc_i;
  logic [N_MASTERS-1:0]        m_stb_i;
  logic [N_MASTERS-1:0]        m_we_i;
  logic [N_MASTERS*3-1:0]      m_cti_i;
  logic [N_MASTERS*2-1:0]      m_bte_i;
  logic [DW-1:0]               m_dat_o;
  logic [N_MASTERS-1:0]        m_ack_o;
  logic [N_MASTERS-1:0]        m_err_o;
  logic [AW-1:0]               s_adr_o;
  logic [DW-1:0]               s_dat_o;
  logic [DW/8-1:0]             s_sel_o;
  logic                        s_cyc_o;
  logic                        s_stb_o;
  logic                        s_we_o;
  logic [2:0]                  s_cti_o;
  logic [1:0]                  s_bte_o;
  logic [DW-1:0]               s_dat_i;
  logic                        s_ack_i;
  logic                        s_err_i;
  logic [GW-1:0]               grant_o;
  logic                        timeout_o;
  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i, m_cti_i, m_bte_i,
    input  s_dat_i, s_ack_i, s_err_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, s_cti_o, s_bte_o,
    output grant_o, timeout_o
  );
  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i, m_cti_i, m_bte_i,
    output s_dat_i, s_ack_i, s_err_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, s_cti_o, s_bte_o,
    input  grant_o, timeout_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: N-master to one-slave Wishbone round-robin arbiter with an optional watchdog
// Ports:
//   sys_clk   : system clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   bus       : wb_rr_arbiter_if.slave, which carries the master requests and the muxed slave bus.
//               It also carries the per-master ack/err, the broadcast read data,
//               grant_o (the current owner) and timeout_o (the watchdog pulse).
// Build option: define WB_ARB_TIMEOUT_EN to compile in the bus-timeout watchdog.
module wb_rr_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int AW        = 30,
  parameter int DW        = 32,
  parameter int TIMEOUT   = 1024
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  wb_rr_arbiter_if.slave bus
);
  localparam int GW = $clog2(N_MASTERS);
  localparam int SW = DW / 8;
  if (N_MASTERS < 2 || N_MASTERS > 16 || TIMEOUT < 2) begin : g_param_check
    $error("wb_rr_arbiter: N_MASTERS must be 2..16 and TIMEOUT >= 2");
  end
  logic [GW-1:0]        grant_q, grant_d;
  logic [N_MASTERS-1:0] own;
  logic                 to_err;
  // Rotating search: walk k from far to near so the nearest requester after grant wins.
  // k == N_MASTERS lands on the current owner, so the owner is considered last.
  always_comb begin
    grant_d = grant_q;
    if (!bus.m_cyc_i[grant_q])
      for (int k = N_MASTERS; k >= 1; k--)
        if (bus.m_cyc_i[GW'((int'(grant_q) + k) % N_MASTERS)])
          grant_d = GW'((int'(grant_q) + k) % N_MASTERS);
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) grant_q <= '0;
    else            grant_q <= grant_d;
  assign own         = {{(N_MASTERS-1){1'b0}}, 1'b1} << grant_q;
  assign bus.grant_o = grant_q;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_ack_o = bus.s_ack_i ? own : '0;
  assign bus.m_err_o = (bus.s_err_i | to_err) ? own : '0;
  assign bus.s_adr_o = bus.m_adr_i[grant_q*AW +: AW];
  assign bus.s_dat_o = bus.m_dat_i[grant_q*DW +: DW];
  assign bus.s_sel_o = bus.m_sel_i[grant_q*SW +: SW];
  assign bus.s_we_o  = bus.m_we_i[grant_q];
  assign bus.s_cti_o = bus.m_cti_i[grant_q*3 +: 3];
  assign bus.s_bte_o = bus.m_bte_i[grant_q*2 +: 2];
  // A watchdog termination withdraws the strobe, so the slave ignores the abandoned cycle.
  assign bus.s_cyc_o = bus.m_cyc_i[grant_q] & ~to_err;
  assign bus.s_stb_o = bus.m_stb_i[grant_q] & ~to_err;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_err_q, to_err_d, stall;
  // to_err is registered, so it is armed one count early.
  // That lands the pulse on the TIMEOUT-th stalled cycle, while the count reads TIMEOUT-1.
  always_comb begin
    stall    = bus.s_cyc_o & bus.s_stb_o & ~bus.s_ack_i & ~bus.s_err_i;
    to_cnt_d = (stall && grant_d == grant_q) ? to_cnt_q + 1'b1 : '0;
    to_err_d = stall && grant_d == grant_q && to_cnt_q == TW'(TIMEOUT - 2);
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  assign to_err = to_err_q;
`else
  assign to_err = 1'b0;
`endif
  assign bus.timeout_o = to_err;
endmodule
